// File: rtl/pixel_frame_loader_pkg.sv
// net_pkg: definitions shared between the pixel frame loader and the network
// stage it feeds.
//   NET_HEIGHT / NET_WIDTH : default network input count and weight width
//   loader_state_t         : loader FSM states
//   sweep_cycles()         : cycles the network needs for one full evaluation
package net_pkg;

  localparam int unsigned NET_HEIGHT = 7;
  localparam int unsigned NET_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SWAP = 2'd1,
    RUN  = 2'd2
  } loader_state_t;

  // One sweep is HEIGHT * 2^(WIDTH+1) cycles.
  function automatic int unsigned sweep_cycles(input int unsigned height,
                                               input int unsigned width);
    return height * (32'd1 << (width + 1));
  endfunction

endpackage

// File: rtl/pixel_frame_loader_if.sv
// Grey-level pixel stream into the frame loader (valid/ready handshake).
//   in_valid : pixel valid (source)
//   in_ready : loader can accept a pixel (loader)
//   in_pixel : grey-level pixel, PIX_BITS wide (source)
//   in_last  : final pixel of a frame (source)
// Modports: master = pixel source, slave = loader.
interface pixel_frame_loader_if #(
  parameter int unsigned PIX_BITS = 8
);

  logic                in_valid;
  logic                in_ready;
  logic [PIX_BITS-1:0] in_pixel;
  logic                in_last;

  modport master (
    output in_valid,
    output in_pixel,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_pixel,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/pixel_frame_loader_frame_shadow_buf.sv
// frame_shadow_buf: binarizes accepted pixels and assembles them into the
// shadow frame that the loader swaps into the active register.
//   clk, rst    : clock, asynchronous active-high reset
//   accept      : a pixel is transferred this cycle
//   clear       : empty the shadow (loader is swapping it out)
//   pixel, last : accepted pixel and its end-of-frame marker
//   thresh      : runtime threshold (only with PIXEL_LOADER_RUNTIME_THRESH_EN)
//   shadow      : assembled binary frame, bit 0 = first pixel
//   shadow_full : frame closed, waiting for the swap
//   short_err   : sticky, a frame was closed early by last
// Macro PIXEL_LOADER_RUNTIME_THRESH_EN: threshold is sampled from thresh on
// the first pixel of each frame instead of using THRESHOLD.
module frame_shadow_buf
  import net_pkg::*;
#(
  parameter int unsigned HEIGHT    = NET_HEIGHT,
  parameter int unsigned PIX_BITS  = 8,
  parameter int unsigned THRESHOLD = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                accept,
  input  logic                clear,
  input  logic [PIX_BITS-1:0] pixel,
  input  logic                last,
`ifdef PIXEL_LOADER_RUNTIME_THRESH_EN
  input  logic [PIX_BITS-1:0] thresh,
`endif
  output logic [HEIGHT-1:0]   shadow,
  output logic                shadow_full,
  output logic                short_err
);

  localparam int unsigned IDX_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(HEIGHT - 1);
  localparam logic [PIX_BITS-1:0] THR_DEF  = PIX_BITS'(THRESHOLD);

  logic [IDX_W-1:0]    idx;
  logic                idx_last;
  logic [PIX_BITS-1:0] thr_eff;
  logic                bit_in;

`ifdef PIXEL_LOADER_RUNTIME_THRESH_EN
  logic [PIX_BITS-1:0] thr_q;

  // The first pixel uses the live input so the whole frame sees one value.
  assign thr_eff = (idx == '0) ? thresh : thr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr_q <= THR_DEF;
    end else if (accept && idx == '0) begin
      thr_q <= thresh;
    end
  end
`else
  assign thr_eff = THR_DEF;
`endif

  assign idx_last = (idx == IDX_LAST);
  assign bit_in   = (pixel >= thr_eff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow      <= '0;
      idx         <= '0;
      shadow_full <= 1'b0;
      short_err   <= 1'b0;
    end else if (clear) begin
      shadow      <= '0;
      idx         <= '0;
      shadow_full <= 1'b0;
    end else if (accept) begin
      // An early last zeroes every position after the current one.
      for (int unsigned i = 0; i < HEIGHT; i++) begin
        if (IDX_W'(i) == idx) begin
          shadow[i] <= bit_in;
        end else if (last && IDX_W'(i) > idx) begin
          shadow[i] <= 1'b0;
        end
      end
      idx <= idx + 1'b1;
      if (last || idx_last) begin
        shadow_full <= 1'b1;
      end
      if (last && !idx_last) begin
        short_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_frame_loader.sv
// pixel_frame_loader: upstream feeder for the network stage. Binarizes a
// pixel stream into a double-buffered frame, holds the active frame stable
// for one network sweep, then swaps in the next frame.
//   clk, rst  : clock, asynchronous active-high reset
//   in_if     : pixel stream (slave modport of pixel_frame_loader_if)
//   thresh    : runtime threshold (only with PIXEL_LOADER_RUNTIME_THRESH_EN)
//   pixels    : active binary frame, bit 0 = first pixel received
//   net_rst_n : active-low network reset, high only while sweeping
//   eval_done : one-cycle strobe on the last sweep cycle
//   short_err : sticky, a frame was closed early by in_last
// Macro PIXEL_LOADER_RUNTIME_THRESH_EN adds the thresh port.
module pixel_frame_loader
  import net_pkg::*;
#(
  parameter int unsigned HEIGHT    = NET_HEIGHT,
  parameter int unsigned WIDTH     = NET_WIDTH,
  parameter int unsigned PIX_BITS  = 8,
  parameter int unsigned THRESHOLD = 128
) (
  input  logic                clk,
  input  logic                rst,
  pixel_frame_loader_if.slave in_if,
`ifdef PIXEL_LOADER_RUNTIME_THRESH_EN
  input  logic [PIX_BITS-1:0] thresh,
`endif
  output logic [HEIGHT-1:0]   pixels,
  output logic                net_rst_n,
  output logic                eval_done,
  output logic                short_err
);

  localparam int unsigned SWEEP = sweep_cycles(HEIGHT, WIDTH);
  localparam int unsigned CNT_W = $clog2(SWEEP);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SWEEP - 1);

  loader_state_t    state_q;
  loader_state_t    state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [HEIGHT-1:0] shadow;
  logic             shadow_full;
  logic             swap;
  logic             accept;

  assign swap           = (state_q == SWAP);
  assign in_if.in_ready = !shadow_full && !swap;
  assign accept         = in_if.in_valid && in_if.in_ready;

  frame_shadow_buf #(
    .HEIGHT    (HEIGHT),
    .PIX_BITS  (PIX_BITS),
    .THRESHOLD (THRESHOLD)
  ) u_shadow (
    .clk         (clk),
    .rst         (rst),
    .accept      (accept),
    .clear       (swap),
    .pixel       (in_if.in_pixel),
    .last        (in_if.in_last),
`ifdef PIXEL_LOADER_RUNTIME_THRESH_EN
    .thresh      (thresh),
`endif
    .shadow      (shadow),
    .shadow_full (shadow_full),
    .short_err   (short_err)
  );

  // The end-of-sweep decision uses the registered shadow_full, so a frame
  // closing on the eval_done cycle is picked up one cycle later from IDLE.
  always_comb begin
    state_d   = state_q;
    net_rst_n = 1'b0;
    eval_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (shadow_full) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        state_d = RUN;
      end
      RUN: begin
        net_rst_n = 1'b1;
        if (cnt_q == CNT_LAST) begin
          eval_done = 1'b1;
          state_d   = shadow_full ? SWAP : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pixels  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        SWAP: begin
          pixels <= shadow;
          cnt_q  <= '0;
        end
        RUN: begin
          cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/pixel_frame_loader.md
Name: pixel_frame_loader

Overview:
- Upstream feeder for the network stage.
- Accepts a stream of grey-level pixels over a valid/ready handshake and binarizes each one against a threshold.
- Assembles HEIGHT binary pixels into a shadow frame, double-buffered so the next frame loads while the current one is evaluated.
- Holds the active frame stable for one full network sweep, then swaps, pulses the network's active-low reset and strobes eval_done so the downstream stage captures the decision.

Parameters:
- HEIGHT, 7, pixels per frame; equals the network's input count.
- WIDTH, 8, network weight width; sets sweep length.
- PIX_BITS, 8, grey-level pixel width.
- THRESHOLD, 128, binarization threshold; pixel bit = (in_pixel >= THRESHOLD).

Ports:
- clk  input  1  system clock, rising-edge logic.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  input pixel valid.
- in_ready  output  1  loader can accept a pixel.
- in_pixel  input  PIX_BITS  grey-level pixel.
- in_last  input  1  marks the final pixel of a frame.
- pixels  output  HEIGHT  active binary frame; index 0 = first pixel received.
- net_rst_n  output  1  active-low reset to the network.
- eval_done  output  1  one-cycle strobe on the last sweep cycle.
- short_err  output  1  sticky flag: a frame closed early on in_last.

Behaviour:
- Reset values: pixels=0, net_rst_n=0, in_ready=1, eval_done=0, short_err=0, state=IDLE, fill index=0, shadow empty, sweep counter=0.
- SWEEP = HEIGHT * 2^(WIDTH+1) cycles (3584 at defaults).
- Handshake: a pixel is accepted when in_valid && in_ready at a rising edge.
  - in_ready = !shadow_full && state != SWAP.
  - in_pixel and in_last matter only on acceptance.
- Fill: the accepted bit is written to shadow[idx] and idx increments.
  - Frame closes (shadow_full=1) when idx reaches HEIGHT-1 on acceptance, or on in_last.
  - in_last before HEIGHT pixels: remaining shadow bits are forced 0 and short_err is set.
  - short_err is cleared only by rst.
  - in_last on exactly the HEIGHT-th pixel is normal.
  - A HEIGHT-th pixel without in_last still closes the frame; the next accepted pixel starts a new frame.
- State IDLE: net_rst_n=0; pixels hold their last value. Goes to SWAP when registered shadow_full=1.
- State SWAP (exactly 1 cycle): pixels <= shadow; shadow cleared; idx=0; shadow_full=0; net_rst_n=0; counter=0. Goes to RUN.
- State RUN: net_rst_n=1 and the counter increments each cycle.
  - When counter == SWEEP-1: eval_done=1 for that cycle.
  - Next state is SWAP if registered shadow_full=1, else IDLE.
- Latency: frame close to first net_rst_n=1 cycle is 2 cycles from IDLE. Back-to-back frames leave a gap of 1 reset cycle between sweeps.
- Simultaneous events:
  - A frame closing in the same cycle as eval_done is not seen by that decision. The FSM goes to IDLE and then to SWAP on the next cycle.
  - Acceptance during SWAP cannot occur (in_ready=0).
- pixels never change during RUN.
- rst mid-sweep or mid-fill: everything returns to reset values immediately; a partial frame is discarded.
- Counter width: $clog2(SWEEP); no wrap-around beyond SWEEP-1.

Optional Feature:
- Macro: PIXEL_LOADER_RUNTIME_THRESH_EN.
- Defined: adds input port thresh [PIX_BITS-1:0]. It is latched when the first pixel of a frame (idx==0) is accepted, and that latched value is used for every pixel of the frame. The latch resets to THRESHOLD.
- Undefined: no port; parameter THRESHOLD is used.

Decomposition:
- Package net_pkg holds:
  - function sweep_cycles(HEIGHT, WIDTH);
  - typedef enum logic [1:0] {IDLE, SWAP, RUN} loader_state_t;
  - localparam defaults shared with the network (HEIGHT=7, WIDTH=8).
- Sub-module frame_shadow_buf covers shadow register, idx counter, shadow_full, the binarize compare, short_err and the optional threshold latch.
- The top level owns the FSM, sweep counter, active register and outputs.

Test Plan:
- Reset then 7 pixels {200,10,130,127,255,0,128} with in_last on the 7th -> shadow 7'b1010101 (bit0 first). SWAP occurs 2 cycles later, then pixels=7'b1010101, net_rst_n rises, eval_done pulses exactly 3584 cycles after the rise, then IDLE with net_rst_n=0.
- Second frame streamed during RUN -> in_ready drops after its 7th pixel. At eval_done the FSM goes to SWAP with 1 cycle of net_rst_n=0, the new pixels appear, and pixels never change mid-sweep.
- in_last on the 3rd pixel {255,255,255} -> pixels=7'b0000111 and short_err=1, remaining set after the next full frame.
- The 7th pixel is accepted on the eval_done cycle -> FSM goes to IDLE for 1 cycle, then SWAP, then RUN.
- rst asserted at counter=1000 with 4 shadow pixels loaded -> all outputs return to reset values the same instant. The next full frame loads from idx 0.
- With PIXEL_LOADER_RUNTIME_THRESH_EN: thresh=50 at first pixel, changed to 250 mid-frame, pixels {60,…,60} -> pixels=7'b1111111.
